clk_step_ctrl: RTL and testbench
================================

# clk_step_ctrl

Clock sequencer that sits directly upstream of the single-cycle RISC-V datapath and generates its two clocks (`oClkCPU` for PC/register-file updates, `oClkMem` for the synchronous instruction ROM and data RAM) from one board clock. It supports free-run and single-step execution from a push button. It can also halt on a PC breakpoint by watching the datapath's PC view output, and it counts retired CPU cycles for the debug display.

## Interface
- `DIV`, default 1: iCLK cycles per phase; must be ≥1.
- `DEBOUNCE`, default 16: consecutive stable synchronized samples required to accept a button level; must be ≥2.
- `iCLK`, in, 1: board clock; the only clock.
- `iRST`, in, 1: synchronous, active-high reset (one clock; reset is synchronous and active-high).
- `iRun`, in, 1: 1 = free-run mode, 0 = step mode; level, assumed quasi-static (switch).
- `iStepBtn`, in, 1: raw, asynchronous step push button, active-high.
- `iBreakEn`, in, 1: enables the breakpoint compare.
- `iBreakAddr`, in, 32: breakpoint PC.
- `iPC`, in, 32: current PC from the datapath.
- `oClkCPU`, out, 1: datapath CPU clock.
- `oClkMem`, out, 1: memory clock.
- `oCycleCnt`, out, 32: number of completed CPU cycles since reset.
- `oState`, out, 3: current FSM state, for LEDs.

## Operation
- A CPU cycle is four phases P0..P3 of DIV iCLK cycles each:
  - P0: mem=1, cpu=0.
  - P1: mem=0, cpu=0.
  - P2: mem=1, cpu=0.
  - P3: mem=0, cpu=1.
- This gives two memory edges per cycle (fetch, then data access) before the single CPU edge.
- Button path: 2-flop synchronizer, then a debounce counter. The debounced level changes only after DEBOUNCE equal samples. A step event is a one-iCLK pulse on a debounced 0→1 transition.
- FSM states:
  - IDLE: clocks low. Moves to RUN if iRun=1. Otherwise moves to STEP on a step event.
  - RUN: issues cycles back-to-back. At the end of each P3:
    - If iBreakEn and iPC==iBreakAddr → BREAK.
    - Else if iRun=0 → IDLE.
    - Else starts the next P0.
  - STEP: issues exactly one cycle, then returns to IDLE. No breakpoint check.
  - BREAK: clocks low. A step event → STEP (one cycle). iRun dropping to 0 → IDLE. Stays in BREAK while iRun=1 and there is no step event.
- Breakpoint compare uses iPC sampled in the iCLK where P3 ends, i.e. the PC after the CPU edge.
- A cycle in progress always completes all four phases. Mode changes and step events take effect only at cycle boundaries. Step events arriving mid-cycle or in RUN are discarded.
- oCycleCnt increments by 1 at the end of each P3 and wraps 0xFFFFFFFF→0.
- Reset effects:
  - oClkCPU=0, oClkMem=0, oCycleCnt=0, state=IDLE.
  - Phase and divider counters are cleared.
  - Debounced level and synchronizer flops are cleared to 0.
  - Reset mid-cycle truncates the cycle immediately.

## Timing
- All outputs are registered and change only on the iCLK rising edge.
- Latency:
  - IDLE→RUN decision takes 1 iCLK; P0 (oClkMem=1) appears on the next edge.
  - Step event → oClkMem high takes 2 iCLK.
- Free-run CPU frequency = f(iCLK)/(4·DIV). oClkCPU duty is 25%; oClkMem has two DIV-wide high pulses per cycle.
- Button press → step event: 2 (sync) + DEBOUNCE iCLK.
- BREAK is entered on the iCLK edge that ends P3. No extra memory or CPU edge follows.
- iRST has priority over every other input in the same cycle.

## Structure
- Shared package `clk_step_pkg`:
  - State encoding: IDLE=0, RUN=1, STEP=2, BREAK=3.
  - Phase constants P0..P3.
  - Per-phase (mem, cpu) output pattern constants.
- Sub-module `btn_debounce`: synchronizer, debounce counter, rising-edge pulse; parameter DEBOUNCE.
- Top contains the FSM, the phase/divider counters and the cycle counter.

## Test plan
All scenarios use DIV=2, DEBOUNCE=4.
- Reset, then iRun=1: oClkMem pattern 1,1,0,0,1,1,0,0; oClkCPU high in iCLK 7–8 of each 8-cycle window; oCycleCnt=3 after 24 iCLK of running.
- Step mode, one button press with 3 cycles of bounce: exactly one oClkCPU pulse, oCycleCnt 0→1, state returns to IDLE.
- iRun=1, iBreakEn=1, iBreakAddr=0x00400003, iPC driven by a model incrementing by 1 per oClkCPU edge: halts in BREAK with iPC=0x00400003 and oCycleCnt=3. A step event then gives one more cycle and oCycleCnt=4.
- Drop iRun in the middle of P1: the cycle completes (P2, P3 emitted), then IDLE; oCycleCnt incremented once.
- Assert iRST during P2: next edge gives both clocks 0, oCycleCnt=0, state=IDLE.
- Preload the counter near wrap (force oCycleCnt=0xFFFFFFFF) and run one cycle: oCycleCnt=0.

Source files
------------

// File: rtl/clk_step_pkg.sv
// Shared definitions for the clock step controller.
// Holds the FSM state encoding, the four phase codes of one CPU cycle,
// and the (mem, cpu) clock levels driven during each phase.
package clk_step_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_STEP  = 3'd2,
      ST_BREAK = 3'd3
   } state_e;

   typedef enum logic [1:0] {
      PH_P0 = 2'd0,
      PH_P1 = 2'd1,
      PH_P2 = 2'd2,
      PH_P3 = 2'd3
   } phase_e;

   typedef struct packed {
      logic mem;
      logic cpu;
   } clk_pat_t;

   // Two memory edges (fetch, then data access) precede the single CPU edge.
   localparam clk_pat_t PAT_P0  = '{mem: 1'b1, cpu: 1'b0};
   localparam clk_pat_t PAT_P1  = '{mem: 1'b0, cpu: 1'b0};
   localparam clk_pat_t PAT_P2  = '{mem: 1'b1, cpu: 1'b0};
   localparam clk_pat_t PAT_P3  = '{mem: 1'b0, cpu: 1'b1};
   localparam clk_pat_t PAT_OFF = '{mem: 1'b0, cpu: 1'b0};

   function automatic clk_pat_t phase_pat(input phase_e ph);
      clk_pat_t p;
      case (ph)
         PH_P0:   p = PAT_P0;
         PH_P1:   p = PAT_P1;
         PH_P2:   p = PAT_P2;
         PH_P3:   p = PAT_P3;
         default: p = PAT_OFF;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/clk_step_ctrl_if.sv
// Datapath/board-side signal bundle of the clock step controller.
//   iRun, iStepBtn, iBreakEn, iBreakAddr, iPC : into the controller
//   oClkCPU, oClkMem, oCycleCnt, oState       : out of the controller
// master = board/datapath side, slave = controller side.
interface clk_step_ctrl_if;
   logic        iRun;
   logic        iStepBtn;
   logic        iBreakEn;
   logic [31:0] iBreakAddr;
   logic [31:0] iPC;
   logic        oClkCPU;
   logic        oClkMem;
   logic [31:0] oCycleCnt;
   logic [2:0]  oState;

   modport master (
      output iRun, iStepBtn, iBreakEn, iBreakAddr, iPC,
      input  oClkCPU, oClkMem, oCycleCnt, oState
   );

   modport slave (
      input  iRun, iStepBtn, iBreakEn, iBreakAddr, iPC,
      output oClkCPU, oClkMem, oCycleCnt, oState
   );
endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce down-counter and
// rising-edge pulse of the debounced level.
//   iCLK   : clock
//   iRST   : synchronous active-high reset
//   btn_i  : raw asynchronous button
//   rise_o : one-clock pulse on a debounced 0->1 transition
module btn_debounce #(
   parameter int DEBOUNCE = 16
) (
   input  logic iCLK,
   input  logic iRST,
   input  logic btn_i,
   output logic rise_o
);

   localparam int            CW       = $clog2(DEBOUNCE);
   localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          level_q;
   logic          rise_q;
   logic [CW-1:0] cnt_q;

   // The counter only runs while the synchronized input disagrees with the
   // accepted level; any agreeing sample restarts the window, so the level
   // flips after exactly DEBOUNCE consecutive disagreeing samples.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= CNT_LOAD;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         rise_q  <= 1'b0;
         if (sync2_q == level_q) begin
            cnt_q <= CNT_LOAD;
         end else if (cnt_q == '0) begin
            level_q <= sync2_q;
            rise_q  <= sync2_q;
            cnt_q   <= CNT_LOAD;
         end else begin
            cnt_q <= cnt_q - CW'(1);
         end
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/clk_step_ctrl.sv
// Clock sequencer for a single-cycle datapath. Produces the memory and CPU
// clocks as a four-phase cycle from iCLK, in free-run or single-step mode,
// with an optional PC breakpoint and a retired-cycle counter.
//   iCLK : board clock
//   iRST : synchronous active-high reset
//   bus  : run/step/breakpoint inputs, generated clocks, cycle count, state
//
//   state | meaning
//   IDLE  | clocks low, waiting for run mode or a step event
//   RUN   | back-to-back cycles, breakpoint checked at each cycle end
//   STEP  | exactly one cycle, then back to IDLE
//   BREAK | halted on breakpoint, clocks low
module clk_step_ctrl
   import clk_step_pkg::*;
#(
   parameter int DIV      = 1,
   parameter int DEBOUNCE = 16
) (
   input logic           iCLK,
   input logic           iRST,
   clk_step_ctrl_if.slave bus
);

   localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_LOAD = DW'(DIV - 1);

   state_e          state_q;
   phase_e          phase_q;
   phase_e          phase_nxt;
   logic [DW-1:0]   div_q;
   logic            act_q;
   clk_pat_t        pat_q;
   logic [31:0]     cnt_q;
   logic [31:0]     cnt_d;
   logic            step_evt;
   logic            end_p3;
   logic            brk_hit;

   btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_btn (
      .iCLK   (iCLK),
      .iRST   (iRST),
      .btn_i  (bus.iStepBtn),
      .rise_o (step_evt)
   );

   assign phase_nxt = phase_e'(phase_q + 2'd1);
   assign end_p3    = ((state_q == ST_RUN) || (state_q == ST_STEP)) && act_q &&
                      (div_q == '0) && (phase_q == PH_P3);
   assign cnt_d     = end_p3 ? cnt_q + 32'd1 : cnt_q;
   // iPC at the end of P3 already reflects the CPU edge of this cycle.
   assign brk_hit   = bus.iBreakEn && (bus.iPC == bus.iBreakAddr);

   // act_q marks a cycle in progress; entering RUN/STEP spends one clock with
   // act_q low so P0 appears on the following edge.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q <= ST_IDLE;
         phase_q <= PH_P0;
         div_q   <= '0;
         act_q   <= 1'b0;
         pat_q   <= PAT_OFF;
         cnt_q   <= '0;
      end else begin
         cnt_q <= cnt_d;
         case (state_q)
            ST_IDLE: begin
               act_q <= 1'b0;
               pat_q <= PAT_OFF;
               if (bus.iRun)
                  state_q <= ST_RUN;
               else if (step_evt)
                  state_q <= ST_STEP;
            end
            ST_RUN, ST_STEP: begin
               if (!act_q) begin
                  act_q   <= 1'b1;
                  phase_q <= PH_P0;
                  div_q   <= DIV_LOAD;
                  pat_q   <= phase_pat(PH_P0);
               end else if (div_q != '0) begin
                  div_q <= div_q - DW'(1);
               end else if (phase_q != PH_P3) begin
                  phase_q <= phase_nxt;
                  div_q   <= DIV_LOAD;
                  pat_q   <= phase_pat(phase_nxt);
               end else begin
                  phase_q <= PH_P0;
                  div_q   <= DIV_LOAD;
                  if (state_q == ST_STEP) begin
                     state_q <= ST_IDLE;
                     act_q   <= 1'b0;
                     pat_q   <= PAT_OFF;
                  end else if (brk_hit) begin
                     state_q <= ST_BREAK;
                     act_q   <= 1'b0;
                     pat_q   <= PAT_OFF;
                  end else if (!bus.iRun) begin
                     state_q <= ST_IDLE;
                     act_q   <= 1'b0;
                     pat_q   <= PAT_OFF;
                  end else begin
                     pat_q <= phase_pat(PH_P0);
                  end
               end
            end
            ST_BREAK: begin
               act_q <= 1'b0;
               pat_q <= PAT_OFF;
               if (step_evt)
                  state_q <= ST_STEP;
               else if (!bus.iRun)
                  state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               act_q   <= 1'b0;
               pat_q   <= PAT_OFF;
            end
         endcase
      end
   end

   assign bus.oClkMem   = pat_q.mem;
   assign bus.oClkCPU   = pat_q.cpu;
   assign bus.oCycleCnt = cnt_q;
   assign bus.oState    = state_q;

endmodule

// File: tb/tb_clk_step_ctrl.sv
module tb_clk_step_ctrl;

   localparam int DIV = 2;
   localparam int DEB = 4;
   localparam int CYC = 4 * DIV;

   logic iCLK = 1'b0;
   logic iRST = 1'b1;

   clk_step_ctrl_if ifc();

   clk_step_ctrl #(.DIV(DIV), .DEBOUNCE(DEB)) dut (
      .iCLK (iCLK),
      .iRST (iRST),
      .bus  (ifc)
   );

   always #5 iCLK = ~iCLK;

   int total = 0;
   int bad   = 0;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // PC model: advances by one on every CPU clock rising edge.
   logic [31:0] pc_base = 32'h0;
   int unsigned pc_edges = 0;
   always @(posedge ifc.oClkCPU) pc_edges = pc_edges + 1;
   assign ifc.iPC = pc_base + pc_edges;

   // Behavioural model: position t inside the 4*DIV-clock cycle (-1 = no cycle),
   // debounced button as a window of the last DEB synchronized samples.
   int          m_state = 0;
   int          m_t     = -1;
   logic [31:0] m_cnt   = 32'h0;
   logic        m_evt   = 1'b0;
   logic        m_lvl   = 1'b0;
   logic        m_s1    = 1'b0;
   logic        m_s2    = 1'b0;
   logic        m_valid = 1'b0;
   logic        hist[$];
   int          preload_req = 0;
   int          preload_ack = 0;

   always @(posedge iCLK) begin
      logic evt;
      bit   flip;
      if (iRST) begin
         m_state = 0; m_t = -1; m_cnt = 32'h0; m_evt = 1'b0;
         m_lvl = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0; hist.delete();
         m_valid = 1'b1;
      end else begin
         evt   = m_evt;
         m_evt = 1'b0;
         hist.push_back(m_s2);
         if (hist.size() > DEB) void'(hist.pop_front());
         flip = (hist.size() == DEB);
         foreach (hist[i]) if (hist[i] == m_lvl) flip = 0;
         if (flip) begin
            m_lvl = ~m_lvl;
            m_evt = m_lvl;
         end
         m_s2 = m_s1;
         m_s1 = ifc.iStepBtn;
         if (preload_req != preload_ack) begin
            m_cnt = 32'hFFFF_FFFF;
            preload_ack = preload_req;
         end
         case (m_state)
            0: if (ifc.iRun) m_state = 1; else if (evt) m_state = 2;
            1, 2: begin
               if (m_t < 0) m_t = 0;
               else if (m_t < CYC - 1) m_t = m_t + 1;
               else begin
                  m_cnt = m_cnt + 32'd1;
                  m_t = -1;
                  if (m_state == 2) m_state = 0;
                  else if (ifc.iBreakEn && ifc.iPC == ifc.iBreakAddr) m_state = 3;
                  else if (!ifc.iRun) m_state = 0;
                  else m_t = 0;
               end
            end
            3: if (evt) m_state = 2; else if (!ifc.iRun) m_state = 0;
            default: m_state = 0;
         endcase
      end
   end

   always @(negedge iCLK) begin
      logic em, ec;
      if (m_valid) begin
         em = (m_t >= 0) && (((m_t / DIV) % 2) == 0);
         ec = (m_t >= 0) && ((m_t / DIV) == 3);
         cmp("mdl_mem",   32'(ifc.oClkMem),  32'(em));
         cmp("mdl_cpu",   32'(ifc.oClkCPU),  32'(ec));
         cmp("mdl_cnt",   ifc.oCycleCnt,     m_cnt);
         cmp("mdl_state", 32'(ifc.oState),   32'(m_state));
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge iCLK);
         #1;
      end
   endtask

   task automatic wait_state(input int s, input int lim, input string nm);
      int n = 0;
      while (ifc.oState != 3'(s) && n < lim) begin
         tick(1);
         n++;
      end
      cmp(nm, 32'(ifc.oState), 32'(s));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit [7:0] mem_pat;
      bit [7:0] cpu_pat;
      int unsigned pc0;
      mem_pat = 8'b0011_0011;
      cpu_pat = 8'b1100_0000;
      ifc.iRun = 1'b0; ifc.iStepBtn = 1'b0; ifc.iBreakEn = 1'b0;
      ifc.iBreakAddr = 32'h0;

      // reset state
      tick(2);
      cmp("rst_mem", 32'(ifc.oClkMem), 32'd0);
      cmp("rst_cpu", 32'(ifc.oClkCPU), 32'd0);
      cmp("rst_cnt", ifc.oCycleCnt, 32'd0);
      cmp("rst_state", 32'(ifc.oState), 32'd0);
      iRST = 1'b0;

      // free run: pattern and count
      ifc.iRun = 1'b1;
      tick(1);
      cmp("run_enter_state", 32'(ifc.oState), 32'd1);
      cmp("run_enter_mem", 32'(ifc.oClkMem), 32'd0);
      for (int i = 0; i < 16; i++) begin
         tick(1);
         cmp("pat_mem", 32'(ifc.oClkMem), 32'(mem_pat[i % 8]));
         cmp("pat_cpu", 32'(ifc.oClkCPU), 32'(cpu_pat[i % 8]));
      end
      tick(8);
      cmp("run_cnt2", ifc.oCycleCnt, 32'd2);
      tick(1);
      cmp("run_cnt3", ifc.oCycleCnt, 32'd3);

      // drop iRun in P1: cycle completes, then IDLE
      tick(2);
      cmp("p1_mem", 32'(ifc.oClkMem), 32'd0);
      ifc.iRun = 1'b0;
      tick(5);
      cmp("drop_p3_cpu", 32'(ifc.oClkCPU), 32'd1);
      cmp("drop_p3_state", 32'(ifc.oState), 32'd1);
      tick(1);
      cmp("drop_state", 32'(ifc.oState), 32'd0);
      cmp("drop_cnt", ifc.oCycleCnt, 32'd4);
      cmp("drop_cpu", 32'(ifc.oClkCPU), 32'd0);

      // step with bouncing button
      pc0 = pc_edges;
      for (int i = 0; i < 6; i++) begin
         ifc.iStepBtn = (i % 2 == 0);
         tick(1);
      end
      ifc.iStepBtn = 1'b1;
      tick(12);
      for (int i = 0; i < 5; i++) begin
         ifc.iStepBtn = (i % 2 == 1);
         tick(1);
      end
      ifc.iStepBtn = 1'b0;
      tick(20);
      cmp("step_cpu_pulses", pc_edges - pc0, 32'd1);
      cmp("step_cnt", ifc.oCycleCnt, 32'd5);
      cmp("step_state", 32'(ifc.oState), 32'd0);

      // breakpoint
      iRST = 1'b1;
      tick(1);
      iRST = 1'b0;
      pc_base = 32'h0040_0000 - pc_edges;
      ifc.iBreakAddr = 32'h0040_0003;
      ifc.iBreakEn = 1'b1;
      ifc.iRun = 1'b1;
      wait_state(3, 100, "brk_reach");
      cmp("brk_pc", ifc.iPC, 32'h0040_0003);
      cmp("brk_cnt", ifc.oCycleCnt, 32'd3);
      tick(6);
      cmp("brk_hold_state", 32'(ifc.oState), 32'd3);
      cmp("brk_hold_mem", 32'(ifc.oClkMem), 32'd0);
      cmp("brk_hold_cnt", ifc.oCycleCnt, 32'd3);
      ifc.iStepBtn = 1'b1;
      wait_state(2, 20, "brk_step");
      ifc.iRun = 1'b0;
      wait_state(0, 20, "brk_step_done");
      cmp("brk_step_cnt", ifc.oCycleCnt, 32'd4);
      cmp("brk_step_pc", ifc.iPC, 32'h0040_0004);
      ifc.iStepBtn = 1'b0;
      ifc.iBreakEn = 1'b0;
      tick(10);

      // reset during P2
      ifc.iRun = 1'b1;
      tick(6);
      cmp("p2_mem", 32'(ifc.oClkMem), 32'd1);
      iRST = 1'b1;
      tick(1);
      cmp("mid_rst_mem", 32'(ifc.oClkMem), 32'd0);
      cmp("mid_rst_cpu", 32'(ifc.oClkCPU), 32'd0);
      cmp("mid_rst_cnt", ifc.oCycleCnt, 32'd0);
      cmp("mid_rst_state", 32'(ifc.oState), 32'd0);
      iRST = 1'b0;
      ifc.iRun = 1'b0;
      tick(2);

      // counter wrap
      @(negedge iCLK);
      #1;
      force dut.cnt_q = 32'hFFFF_FFFF;
      preload_req = preload_req + 1;
      tick(2);
      release dut.cnt_q;
      cmp("wrap_preload", ifc.oCycleCnt, 32'hFFFF_FFFF);
      ifc.iRun = 1'b1;
      tick(3);
      ifc.iRun = 1'b0;
      wait_state(0, 20, "wrap_done");
      cmp("wrap_cnt", ifc.oCycleCnt, 32'd0);
      tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
